// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: drives operands and an opcode to an external combinational
// ALU, waits SETTLE_CYCLES cycles, then captures the ALU result. It runs either
// a single operation (start) or all 16 opcodes in order (sweep).
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   sw_a, sw_b, sw_sel   operand and opcode sources, latched on a trigger
//   start, sweep         triggers, acted on at their rising edge
//   alu_a, alu_b         operands driven to the ALU
//   alu_sel              opcode driven to the ALU
//   alu_out, alu_carry   ALU result and carry, combinational from alu_*
//   result               captured ALU result
//   result_carry         captured carry flag
//   result_op            opcode that produced result
//   result_valid         one-cycle pulse per capture
//   busy                 high while not idle
//   done                 one-cycle pulse on the last capture of a sweep
module alu_op_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw_a,
    input  logic [3:0] sw_b,
    input  logic [3:0] sw_sel,
    input  logic       start,
    input  logic       sweep,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [3:0] alu_sel,
    input  logic [7:0] alu_out,
    input  logic       alu_carry,
    output logic [7:0] result,
    output logic       result_carry,
    output logic [3:0] result_op,
    output logic       result_valid,
    output logic       busy,
    output logic       done
);

    localparam int unsigned OPND_W = 4;
    localparam int unsigned RES_W  = 8;
    localparam int unsigned CNT_W  = 4;

    localparam logic [OPND_W-1:0] LAST_OP     = OPND_W'(15);
    localparam logic [CNT_W-1:0]  SETTLE_INIT = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    typedef enum logic {
        MODE_SINGLE = 1'b0,
        MODE_SWEEP  = 1'b1
    } mode_t;

    state_t             state, state_n;
    mode_t              mode, mode_n;
    logic [CNT_W-1:0]   settle_cnt, settle_cnt_n;
    logic               start_q, sweep_q;
    logic [OPND_W-1:0]  alu_a_n, alu_b_n, alu_sel_n;
    logic [RES_W-1:0]   result_n;
    logic               result_carry_n;
    logic [OPND_W-1:0]  result_op_n;
    logic               result_valid_n;
    logic               busy_n;
    logic               done_n;

    logic start_edge_c;
    logic sweep_edge_c;

    // Trigger edges against the previous-cycle sample.
    assign start_edge_c = start & ~start_q;
    assign sweep_edge_c = sweep & ~sweep_q;

    // Next-state and next-output logic.
    always_comb begin
        state_n        = state;
        mode_n         = mode;
        settle_cnt_n   = settle_cnt;
        alu_a_n        = alu_a;
        alu_b_n        = alu_b;
        alu_sel_n      = alu_sel;
        result_n       = result;
        result_carry_n = result_carry;
        result_op_n    = result_op;
        result_valid_n = 1'b0;
        done_n         = 1'b0;

        unique case (state)
            ST_IDLE: begin
                // start wins over a simultaneous sweep edge.
                if (start_edge_c) begin
                    alu_a_n      = sw_a;
                    alu_b_n      = sw_b;
                    alu_sel_n    = sw_sel;
                    mode_n       = MODE_SINGLE;
                    settle_cnt_n = SETTLE_INIT;
                    state_n      = ST_SETTLE;
                end else if (sweep_edge_c) begin
                    alu_a_n      = sw_a;
                    alu_b_n      = sw_b;
                    alu_sel_n    = '0;
                    mode_n       = MODE_SWEEP;
                    settle_cnt_n = SETTLE_INIT;
                    state_n      = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (settle_cnt == '0) begin
                    state_n = ST_CAPTURE;
                end else begin
                    settle_cnt_n = settle_cnt - CNT_W'(1);
                end
            end

            ST_CAPTURE: begin
                result_n       = alu_out;
                result_carry_n = alu_carry;
                result_op_n    = alu_sel;
                result_valid_n = 1'b1;
                if ((mode == MODE_SWEEP) && (alu_sel != LAST_OP)) begin
                    alu_sel_n    = alu_sel + OPND_W'(1);
                    settle_cnt_n = SETTLE_INIT;
                    state_n      = ST_SETTLE;
                end else begin
                    // A sweep ends on opcode 15 without wrapping alu_sel.
                    done_n  = (mode == MODE_SWEEP);
                    state_n = ST_IDLE;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase

        busy_n = (state_n != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            mode         <= MODE_SINGLE;
            settle_cnt   <= '0;
            start_q      <= 1'b0;
            sweep_q      <= 1'b0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_sel      <= '0;
            result       <= '0;
            result_carry <= 1'b0;
            result_op    <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_n;
            mode         <= mode_n;
            settle_cnt   <= settle_cnt_n;
            start_q      <= start;
            sweep_q      <= sweep;
            alu_a        <= alu_a_n;
            alu_b        <= alu_b_n;
            alu_sel      <= alu_sel_n;
            result       <= result_n;
            result_carry <= result_carry_n;
            result_op    <= result_op_n;
            result_valid <= result_valid_n;
            busy         <= busy_n;
            done         <= done_n;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a model of the team 4-bit ALU.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sw_a = '0, sw_b = '0, sw_sel = '0, sw_a3 = '0;
    logic       start = 1'b0, sweep = 1'b0, start3 = 1'b0, sweep3 = 1'b0;

    logic [3:0] alu_a, alu_b, alu_sel, result_op;
    logic [7:0] alu_out, result;
    logic       alu_carry, result_carry, result_valid, busy, done;

    logic [3:0] alu_a3, alu_b3, alu_sel3, result_op3;
    logic [7:0] alu_out3, result3;
    logic       alu_carry3, result_carry3, result_valid3, busy3, done3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Team ALU: {carry, out}. Carry is the adder carry-out, 0 otherwise.
    function automatic logic [8:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] sel);
        logic [7:0] r;
        logic       c;
        c = 1'b0;
        case (sel)
            4'd0: begin r = 8'(a) + 8'(b); c = r[4]; end
            4'd1: r = 8'(a - b);
            4'd2: r = 8'(a) * 8'(b);
            4'd3: r = (b == 4'd0) ? 8'd0 : 8'(a / b);
            4'd4: r = 8'(4'(a << 1));
            4'd5: r = 8'(a >> 1);
            4'd6: r = 8'({a[2:0], a[3]});
            4'd7: r = 8'({a[0], a[3:1]});
            4'd8: r = 8'(a & b);
            4'd9: r = 8'(a | b);
            4'd10: r = 8'(a ^ b);
            4'd11: r = ~8'(a | b);
            4'd12: r = ~8'(a & b);
            4'd13: r = ~8'(a ^ b);
            4'd14: r = 8'(a > b);
            default: r = 8'(a == b);
        endcase
        return {c, r};
    endfunction

    assign {alu_carry, alu_out}   = alu_f(alu_a, alu_b, alu_sel);
    assign {alu_carry3, alu_out3} = alu_f(alu_a3, alu_b3, alu_sel3);

    alu_op_sequencer #(.SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .sw_a(sw_a), .sw_b(sw_b), .sw_sel(sw_sel),
        .start(start), .sweep(sweep), .alu_a(alu_a), .alu_b(alu_b),
        .alu_sel(alu_sel), .alu_out(alu_out), .alu_carry(alu_carry),
        .result(result), .result_carry(result_carry), .result_op(result_op),
        .result_valid(result_valid), .busy(busy), .done(done)
    );

    alu_op_sequencer #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .sw_a(sw_a3), .sw_b(sw_b), .sw_sel(sw_sel),
        .start(start3), .sweep(sweep3), .alu_a(alu_a3), .alu_b(alu_b3),
        .alu_sel(alu_sel3), .alu_out(alu_out3), .alu_carry(alu_carry3),
        .result(result3), .result_carry(result_carry3), .result_op(result_op3),
        .result_valid(result_valid3), .busy(busy3), .done(done3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({alu_a, alu_b, alu_sel} !== 12'h000) begin
            errors++; $display("FAIL reset_alu_ops got %h expected 000", {alu_a, alu_b, alu_sel});
        end
        checks++;
        if ({result, result_carry, result_op} !== 13'h0) begin
            errors++; $display("FAIL reset_result got %h expected 0", {result, result_carry, result_op});
        end
        checks++;
        if ({result_valid, busy, done} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b expected 000", {result_valid, busy, done});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single(input logic [3:0] a, input logic [3:0] b, input logic [3:0] sel,
                               input logic [7:0] exp_r, input logic exp_c);
        sw_a = a; sw_b = b; sw_sel = sel; start = 1'b1;
        tick();                       // edge k
        start = 1'b0;
        checks++;
        if ({busy, result_valid, alu_a, alu_b, alu_sel} !== {2'b10, a, b, sel}) begin
            errors++; $display("FAIL single_k got %h expected %h",
                               {busy, result_valid, alu_a, alu_b, alu_sel}, {2'b10, a, b, sel});
        end
        tick();                       // edge k+1
        checks++;
        if ({busy, result_valid} !== 2'b10) begin
            errors++; $display("FAIL single_k1 busy/valid got %b expected 10", {busy, result_valid});
        end
        tick();                       // edge k+2
        checks++;
        if ({result_valid, busy, result, result_carry, result_op} !== {2'b10, exp_r, exp_c, sel}) begin
            errors++; $display("FAIL single_capture got %h expected %h",
                               {result_valid, busy, result, result_carry, result_op},
                               {2'b10, exp_r, exp_c, sel});
        end
        tick();
        checks++;
        if ({result_valid, result} !== {1'b0, exp_r}) begin
            errors++; $display("FAIL single_hold got %h expected %h", {result_valid, result}, {1'b0, exp_r});
        end
    endtask

    task automatic test_sweep();
        logic [7:0] exp_tab [16] = '{8'h08, 8'h04, 8'h0C, 8'h03, 8'h0C, 8'h03, 8'h0C, 8'h03,
                                     8'h02, 8'h06, 8'h04, 8'hF9, 8'hFD, 8'hFB, 8'h01, 8'h00};
        int n = 0, last = 0, dones = 0;
        sw_a = 4'd6; sw_b = 4'd2; sweep = 1'b1;
        tick();
        sweep = 1'b0;
        for (int cyc = 1; cyc <= 50 && n < 16; cyc++) begin
            tick();
            if (done) dones++;
            if (result_valid) begin
                checks++;
                if ({result, result_op} !== {exp_tab[n], 4'(n)}) begin
                    errors++; $display("FAIL sweep_result[%0d] got %h expected %h", n,
                                       {result, result_op}, {exp_tab[n], 4'(n)});
                end
                checks++;
                if (cyc - last !== 2) begin
                    errors++; $display("FAIL sweep_spacing[%0d] got %0d expected 2", n, cyc - last);
                end
                checks++;
                if ({done, busy} !== {(n == 15), (n != 15)}) begin
                    errors++; $display("FAIL sweep_done_busy[%0d] got %b expected %b", n,
                                       {done, busy}, {(n == 15), (n != 15)});
                end
                last = cyc;
                n++;
            end
        end
        tick();
        if (done) dones++;
        checks++;
        if (n !== 16 || dones !== 1) begin
            errors++; $display("FAIL sweep_count got %0d captures %0d dones expected 16 1", n, dones);
        end
        checks++;
        if ({alu_sel, busy, result_valid} !== {4'hF, 2'b00}) begin
            errors++; $display("FAIL sweep_end got %h expected %h", {alu_sel, busy, result_valid}, {4'hF, 2'b00});
        end
    endtask

    task automatic test_level_hold();
        int caps = 0;
        sw_a = 4'd9; sw_b = 4'd4; sw_sel = 4'd1; start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (result_valid) caps++;
        end
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (result_valid) caps++;
        end
        checks++;
        if (caps !== 1 || result !== 8'h05) begin
            errors++; $display("FAIL level_hold got %0d captures result %h expected 1 05", caps, result);
        end
    endtask

    task automatic test_simultaneous();
        int caps = 0, dones = 0;
        sw_a = 4'd3; sw_b = 4'd4; sw_sel = 4'd2; start = 1'b1; sweep = 1'b1;
        tick();
        start = 1'b0; sweep = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (result_valid) caps++;
            if (done) dones++;
        end
        checks++;
        if (caps !== 1 || dones !== 0 || {result, result_op} !== 12'h0C2) begin
            errors++; $display("FAIL simultaneous got caps %0d dones %0d res %h expected 1 0 0c2",
                               caps, dones, {result, result_op});
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n = 0, caps = 0, dones = 0;
        sw_a = 4'd6; sw_b = 4'd2; sweep = 1'b1;
        tick();
        sweep = 1'b0;
        for (int i = 0; i < 30 && n < 5; i++) begin
            tick();
            if (result_valid) n++;
        end
        checks++;
        if (n !== 5) begin
            errors++; $display("FAIL abort_reach5 got %0d expected 5", n);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({alu_a, alu_b, alu_sel, result, result_carry, result_op, result_valid, busy, done} !== 28'h0) begin
            errors++; $display("FAIL abort_zero got %h expected 0",
                               {alu_a, alu_b, alu_sel, result, result_carry, result_op, result_valid, busy, done});
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            if (result_valid) caps++;
            if (done) dones++;
        end
        checks++;
        if (caps !== 0 || dones !== 0) begin
            errors++; $display("FAIL abort_quiet got caps %0d dones %0d expected 0 0", caps, dones);
        end
    endtask

    task automatic test_reset_held_start();
        sw_a = 4'd1; sw_b = 4'd2; sw_sel = 4'd0;
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0;
        tick();                       // first post-reset edge
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL held_start_busy got %b expected 1", busy);
        end
        tick();
        tick();
        checks++;
        if ({result_valid, result} !== 9'h103) begin
            errors++; $display("FAIL held_start_result got %h expected 103", {result_valid, result});
        end
        start = 1'b0;
        tick();
    endtask

    task automatic test_settle3();
        sw_a3 = 4'd2; sw_b = 4'd3; sw_sel = 4'd0; start3 = 1'b1;
        tick();                       // edge k
        start3 = 1'b0;
        sw_a3 = 4'd7;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if ({result_valid3, busy3, alu_a3} !== {2'b01, 4'd2}) begin
                errors++; $display("FAIL settle3_wait[%0d] got %h expected %h", i,
                                   {result_valid3, busy3, alu_a3}, {2'b01, 4'd2});
            end
        end
        tick();                       // edge k+4
        checks++;
        if ({result_valid3, result3, result_op3} !== {1'b1, 8'h05, 4'd0}) begin
            errors++; $display("FAIL settle3_capture got %h expected %h",
                               {result_valid3, result3, result_op3}, {1'b1, 8'h05, 4'd0});
        end
    endtask

    initial begin
        test_reset();
        test_single(4'd5, 4'd3, 4'd0, 8'h08, 1'b0);
        test_single(4'hF, 4'hF, 4'd0, 8'h1E, 1'b1);
        test_sweep();
        test_level_hold();
        test_simultaneous();
        test_reset_mid_sweep();
        test_reset_held_start();
        test_settle3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
